// File: rtl/single_port_ram.sv
// Single-port synchronous RAM: read-first, registered dout, 1-cycle read latency.
// No backpressure: always ready, one read (plus optional write) per clock edge.
module single_port_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Array has no reset; writes are blocked while rst_n is low.
    always_ff @(posedge clk) begin
        if (rst_n && we) begin
            mem[addr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else begin
            dout <= mem[addr];
        end
    end

endmodule

// File: tb/tb_single_port_ram.sv
module tb_single_port_ram;

    logic       clk;
    logic       clk_run;
    logic       rst_n;
    logic       we;
    logic [7:0] addr;
    logic [7:0] din;
    logic [7:0] dout;

    int checks;
    int failures;

    // Reference model: plain array plus a "has been written" flag per word.
    logic [7:0] ref_mem   [256];
    bit         ref_valid [256];
    logic [7:0] exp_dout;
    bit         exp_known;

    single_port_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (we),
        .addr (addr),
        .din  (din),
        .dout (dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = clk_run ? ~clk : 1'b0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end

    // One clock edge with the given inputs; computes the expected dout after it.
    task automatic cyc(input logic w, input logic [7:0] a, input logic [7:0] d);
        we = w; addr = a; din = d;
        @(posedge clk);
        #1;
        if (rst_n) begin
            exp_known = ref_valid[a];
            exp_dout  = ref_mem[a];
            if (w) begin
                ref_mem[a]   = d;
                ref_valid[a] = 1'b1;
            end
        end else begin
            exp_known = 1'b1;
            exp_dout  = 8'h00;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        checks++;
        if (dout !== 8'h00) begin
            failures++;
            $display("FAIL reset_idle: dout=%h required=00", dout);
        end
        clk_run = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1'b1, 8'd1, 8'h12);
        checks++;
        if (dout === 8'h12) begin
            failures++;
            $display("FAIL reset_first_write_readfirst: dout=%h required old contents, not 12", dout);
        end
        cyc(1'b0, 8'd1, 8'h00);
        checks++;
        if (dout !== 8'h12) begin
            failures++;
            $display("FAIL reset_release_read: dout=%h required=12", dout);
        end
    endtask

    task automatic test_basic;
        cyc(1'b1, 8'd5, 8'hAA);
        cyc(1'b0, 8'd5, 8'h00);
        checks++;
        if (dout !== 8'hAA) begin
            failures++;
            $display("FAIL basic_rd5: dout=%h required=aa", dout);
        end
    endtask

    task automatic test_alias;
        logic [7:0] seq_a [3];
        logic [7:0] seq_e [3];
        cyc(1'b1, 8'd10, 8'h55);
        seq_a[0] = 8'd10; seq_e[0] = 8'h55;
        seq_a[1] = 8'd5;  seq_e[1] = 8'hAA;
        seq_a[2] = 8'd10; seq_e[2] = 8'h55;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, seq_a[i], 8'h00);
            checks++;
            if (dout !== seq_e[i]) begin
                failures++;
                $display("FAIL alias_rd%0d addr=%0d: dout=%h required=%h", i, seq_a[i], dout, seq_e[i]);
            end
        end
    endtask

    task automatic test_read_first;
        cyc(1'b1, 8'd5, 8'h3C);
        checks++;
        if (dout !== 8'hAA) begin
            failures++;
            $display("FAIL read_first_old: dout=%h required=aa", dout);
        end
        cyc(1'b0, 8'd5, 8'h00);
        checks++;
        if (dout !== 8'h3C) begin
            failures++;
            $display("FAIL read_first_new: dout=%h required=3c", dout);
        end
        cyc(1'b1, 8'd5, 8'hAA);
    endtask

    task automatic test_reset_mid;
        cyc(1'b0, 8'd10, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dout !== 8'h00) begin
            failures++;
            $display("FAIL reset_mid_async: dout=%h required=00", dout);
        end
        cyc(1'b1, 8'd5, 8'h77);
        checks++;
        if (dout !== 8'h00) begin
            failures++;
            $display("FAIL reset_mid_hold: dout=%h required=00", dout);
        end
        rst_n = 1'b1;
        cyc(1'b0, 8'd5, 8'h00);
        checks++;
        if (dout !== 8'hAA) begin
            failures++;
            $display("FAIL reset_mid_rd5: dout=%h required=aa", dout);
        end
        cyc(1'b0, 8'd10, 8'h00);
        checks++;
        if (dout !== 8'h55) begin
            failures++;
            $display("FAIL reset_mid_rd10: dout=%h required=55", dout);
        end
    endtask

    task automatic test_boundary;
        cyc(1'b1, 8'd0,   8'h01);
        cyc(1'b1, 8'd255, 8'hFF);
        cyc(1'b0, 8'd0,   8'h00);
        checks++;
        if (dout !== 8'h01) begin
            failures++;
            $display("FAIL boundary_rd0: dout=%h required=01", dout);
        end
        cyc(1'b0, 8'd255, 8'h00);
        checks++;
        if (dout !== 8'hFF) begin
            failures++;
            $display("FAIL boundary_rd255: dout=%h required=ff", dout);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] a;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 8'(i + 100), 8'($urandom));
        end
        for (int i = 0; i < 400; i++) begin
            a = 8'($urandom);
            cyc(($urandom_range(0, 2) == 0), a, 8'($urandom));
            if (exp_known) begin
                checks++;
                if (dout !== exp_dout) begin
                    failures++;
                    $display("FAIL random_%0d addr=%0d: dout=%h required=%h", i, a, dout, exp_dout);
                end
            end
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        clk_run = 1'b0;
        rst_n = 1'b1; we = 1'b0; addr = '0; din = '0;
        exp_dout = '0; exp_known = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = '0;
            ref_valid[i] = 1'b0;
        end
        test_reset();
        test_basic();
        test_alias();
        test_read_first();
        test_reset_mid();
        test_boundary();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
